rtc_disp_format: RTL and testbench

Formats DS1302 BCD calendar registers into the eight 4-bit digit codes consumed by the eight-digit seven-segment scan driver. Sits between the DS1302 read controller, which supplies BCD registers and a valid strobe, and the scan driver, whose `bit_7`..`bit_0` inputs it drives. A two-state mode machine selects time (`HH-MM-SS`) or date (`YY-MM-DD`). A debounced key toggles the mode, and date mode returns to time mode automatically after a hold period.

---
 rtl/rtc_disp_pkg.sv | 25 ++
 rtl/ms_tick_gen.sv | 37 +++
 rtl/rtc_disp_format.sv | 204 ++++++++++++++++++++
 tb/tb_rtc_disp_format.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtc_disp_pkg
// Description : Shared digit codes, mode-state encoding and prescaler default
//               for the DS1302 seven-segment display formatter.
// Revision    : 1.0 - initial release
// ============================================================================
package rtc_disp_pkg;

    localparam logic [3:0] DIG_BLANK       = 4'd10;
    localparam logic [3:0] DIG_DASH        = 4'd11;
    localparam int         DEF_CNT_1MS_MAX = 49_999;

    typedef enum logic [0:0] {
        S_TIME = 1'b0,
        S_DATE = 1'b1
    } mode_state_t;

    // Non-decimal nibbles show as a dash rather than a bogus glyph.
    function automatic logic [3:0] digit_code(input logic [3:0] nib);
        return (nib > 4'd9) ? DIG_DASH : nib;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ms_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : ms_tick_gen
// Description : Wrapping prescaler emitting a one-cycle tick whenever the
//               count equals CNT_MAX; i_clr restarts the count from zero.
// Revision    : 1.0 - initial release
// ============================================================================
module ms_tick_gen
    import rtc_disp_pkg::*;
#(
    parameter int CNT_MAX = DEF_CNT_1MS_MAX
) (
    input  logic sclk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int              c_w   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [c_w-1:0]  c_max = c_w'(CNT_MAX);

    logic [c_w-1:0] r_cnt;

    assign o_tick = (r_cnt == c_max);

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rtc_disp_format.sv
`default_nettype none
// ============================================================================
// Module      : rtc_disp_format
// Description : Formats DS1302 BCD registers into eight digit codes, with a
//               key-toggled time/date mode and timed return to time mode.
//               Optional separator blink is enabled by defining COLON_BLINK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_disp_format
    import rtc_disp_pkg::*;
#(
    parameter int CNT_1MS_MAX  = DEF_CNT_1MS_MAX,
    parameter int DATE_HOLD_MS = 5000
`ifdef COLON_BLINK_EN
    ,
    parameter int BLINK_HALF_MS = 500
`endif
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       rtc_vld,
    input  logic [7:0] rtc_sec,
    input  logic [7:0] rtc_min,
    input  logic [7:0] rtc_hour,
    input  logic [7:0] rtc_date,
    input  logic [7:0] rtc_mon,
    input  logic [7:0] rtc_year,
    input  logic       key_mode,
    output logic [3:0] bit_7,
    output logic [3:0] bit_6,
    output logic [3:0] bit_5,
    output logic [3:0] bit_4,
    output logic [3:0] bit_3,
    output logic [3:0] bit_2,
    output logic [3:0] bit_1,
    output logic [3:0] bit_0,
    output logic       mode_date
);

    localparam logic [15:0] c_hold_last = 16'(DATE_HOLD_MS - 1);

    mode_state_t      r_state;
    mode_state_t      w_state_nxt;
    logic [6:0]       r_sec;
    logic [7:0]       r_min;
    logic [5:0]       r_hour;
    logic [7:0]       r_date;
    logic [7:0]       r_mon;
    logic [7:0]       r_year;
    logic             r_have_data;
    logic [15:0]      r_hold_cnt;
    logic             w_hold_clr;
    logic             w_hold_tick;
    logic             w_timeout;
    logic [7:0]       w_left;
    logic [7:0]       w_mid;
    logic [7:0]       w_right;
    logic [3:0]       w_sep;
    logic [7:0][3:0]  r_dig;
    logic             w_unused;

    // CH flag and 12/24-hour control bits carry no display information.
    assign w_unused = ^{rtc_sec[7], rtc_hour[7:6]};

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_sec       <= '0;
            r_min       <= '0;
            r_hour      <= '0;
            r_date      <= '0;
            r_mon       <= '0;
            r_year      <= '0;
            r_have_data <= 1'b0;
        end else if (rtc_vld) begin
            r_sec       <= rtc_sec[6:0];
            r_min       <= rtc_min;
            r_hour      <= rtc_hour[5:0];
            r_date      <= rtc_date;
            r_mon       <= rtc_mon;
            r_year      <= rtc_year;
            r_have_data <= 1'b1;
        end
    end

    // Prescaler is held in time mode so each date visit lasts exactly the hold period.
    assign w_hold_clr = (r_state != S_DATE);

    ms_tick_gen #(
        .CNT_MAX (CNT_1MS_MAX)
    ) u_hold_tick (
        .sclk   (sclk),
        .rst    (rst),
        .i_clr  (w_hold_clr),
        .o_tick (w_hold_tick)
    );

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_hold_cnt <= '0;
        end else if (w_hold_clr) begin
            r_hold_cnt <= '0;
        end else if (w_hold_tick) begin
            r_hold_cnt <= r_hold_cnt + 16'd1;
        end
    end

    assign w_timeout = (r_state == S_DATE) && w_hold_tick && (r_hold_cnt == c_hold_last);

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_state <= S_TIME;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_TIME:  if (key_mode) w_state_nxt = S_DATE;
            S_DATE:  if (key_mode || w_timeout) w_state_nxt = S_TIME;
            default: w_state_nxt = S_TIME;
        endcase
    end

    assign mode_date = (r_state == S_DATE);

`ifdef COLON_BLINK_EN
    localparam logic [15:0] c_blink_last = 16'(BLINK_HALF_MS - 1);

    logic        w_sec_chg;
    logic        w_blink_tick;
    logic        r_blink_phase;
    logic [15:0] r_blink_cnt;

    assign w_sec_chg = rtc_vld && (rtc_sec[6:0] != r_sec);

    ms_tick_gen #(
        .CNT_MAX (CNT_1MS_MAX)
    ) u_blink_tick (
        .sclk   (sclk),
        .rst    (rst),
        .i_clr  (w_sec_chg),
        .o_tick (w_blink_tick)
    );

    // A new second restarts the blink so the dash phase lines up with it.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_sec_chg) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_blink_tick) begin
            if (r_blink_cnt == c_blink_last) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt   <= r_blink_cnt + 16'd1;
            end
        end
    end

    assign w_sep = r_blink_phase ? DIG_BLANK : DIG_DASH;
`else
    assign w_sep = DIG_DASH;
`endif

    always_comb begin
        w_left  = {2'b00, r_hour};
        w_mid   = r_min;
        w_right = {1'b0, r_sec};
        if (r_state == S_DATE) begin
            w_left  = r_year;
            w_mid   = r_mon;
            w_right = r_date;
        end
    end

    // Display stays blank until the first capture after reset.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_dig <= {8{DIG_BLANK}};
        end else if (!r_have_data) begin
            r_dig <= {8{DIG_BLANK}};
        end else begin
            r_dig <= {digit_code(w_left[7:4]),  digit_code(w_left[3:0]),  w_sep,
                      digit_code(w_mid[7:4]),   digit_code(w_mid[3:0]),   w_sep,
                      digit_code(w_right[7:4]), digit_code(w_right[3:0])};
        end
    end

    assign bit_7 = r_dig[7];
    assign bit_6 = r_dig[6];
    assign bit_5 = r_dig[5];
    assign bit_4 = r_dig[4];
    assign bit_3 = r_dig[3];
    assign bit_2 = r_dig[2];
    assign bit_1 = r_dig[1];
    assign bit_0 = r_dig[0];

endmodule
`default_nettype wire

// File: tb/tb_rtc_disp_format.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtc_disp_format
// Description : Self-checking bench for rtc_disp_format against a cycle-level
//               behavioural model of the display rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_disp_format;

    localparam int CNT_MAX  = 9;
    localparam int HOLD_MS  = 3;
    localparam int HOLD_CYC = (CNT_MAX + 1) * HOLD_MS;

    logic       sclk = 1'b0;
    logic       rst;
    logic       rtc_vld;
    logic [7:0] rtc_sec, rtc_min, rtc_hour, rtc_date, rtc_mon, rtc_year;
    logic       key_mode;
    logic [3:0] bit_7, bit_6, bit_5, bit_4, bit_3, bit_2, bit_1, bit_0;
    logic       mode_date;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    int m_sec, m_min, m_hour, m_date, m_mon, m_year;
    bit m_have;
    bit m_mode;
    int m_age;

    rtc_disp_format #(
        .CNT_1MS_MAX  (CNT_MAX),
        .DATE_HOLD_MS (HOLD_MS)
`ifdef COLON_BLINK_EN
        ,
        .BLINK_HALF_MS(2)
`endif
    ) dut (
        .sclk      (sclk),
        .rst       (rst),
        .rtc_vld   (rtc_vld),
        .rtc_sec   (rtc_sec),
        .rtc_min   (rtc_min),
        .rtc_hour  (rtc_hour),
        .rtc_date  (rtc_date),
        .rtc_mon   (rtc_mon),
        .rtc_year  (rtc_year),
        .key_mode  (key_mode),
        .bit_7     (bit_7),
        .bit_6     (bit_6),
        .bit_5     (bit_5),
        .bit_4     (bit_4),
        .bit_3     (bit_3),
        .bit_2     (bit_2),
        .bit_1     (bit_1),
        .bit_0     (bit_0),
        .mode_date (mode_date)
    );

    always #5 sclk = ~sclk;

    function automatic logic [31:0] obs_digits();
        return {bit_7, bit_6, bit_5, bit_4, bit_3, bit_2, bit_1, bit_0};
    endfunction

    function automatic logic [3:0] dcode(input int nib);
        return (nib > 9) ? 4'd11 : 4'(nib);
    endfunction

    function automatic logic [31:0] model_digits();
        int a, b, c;
        if (!m_have) return {8{4'd10}};
        if (m_mode) begin
            a = m_year; b = m_mon; c = m_date;
        end else begin
            a = m_hour; b = m_min; c = m_sec;
        end
        return {dcode(a / 16), dcode(a % 16), 4'd11,
                dcode(b / 16), dcode(b % 16), 4'd11,
                dcode(c / 16), dcode(c % 16)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sec = 0; m_min = 0; m_hour = 0; m_date = 0; m_mon = 0; m_year = 0;
        m_have = 0; m_mode = 0; m_age = 0;
    endtask

    // One clock cycle: drive inputs, advance the model, compare after the edge.
    task automatic step(input bit vld, input logic [7:0] s, input logic [7:0] mi,
                        input logic [7:0] h, input logic [7:0] d, input logic [7:0] mo,
                        input logic [7:0] y, input bit key);
        logic [31:0] exp_d;
        exp_d    = model_digits();
        rtc_vld  = vld;
        rtc_sec  = s;  rtc_min = mi; rtc_hour = h;
        rtc_date = d;  rtc_mon = mo; rtc_year = y;
        key_mode = key;
        if (vld) begin
            m_sec = s % 128; m_min = mi; m_hour = h % 64;
            m_date = d; m_mon = mo; m_year = y;
            m_have = 1;
        end
        if (m_mode) begin
            if (key || m_age == HOLD_CYC) begin
                m_mode = 0; m_age = 0;
            end else begin
                m_age++;
            end
        end else if (key) begin
            m_mode = 1; m_age = 1;
        end
        @(posedge sclk); #1;
        rtc_vld  = 1'b0;
        key_mode = 1'b0;
        check("model_mode", {31'd0, mode_date}, {31'd0, m_mode});
        check("model_digits", obs_digits(), exp_d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    endtask

    task automatic key_press();
        step(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_digits", obs_digits(), {8{4'd10}});
        check("rst_mode", {31'd0, mode_date}, 32'd0);
        @(posedge sclk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int cnt;
        rst = 1'b1; rtc_vld = 1'b0; key_mode = 1'b0;
        rtc_sec = '0; rtc_min = '0; rtc_hour = '0; rtc_date = '0; rtc_mon = '0; rtc_year = '0;
        model_reset();
        repeat (2) @(posedge sclk);
        #1;
        do_reset();
        idle(2);
        check("blank_before_data", obs_digits(), {8{4'd10}});

        // Time display with CH bit set in seconds
        step(1, 8'h85, 8'h34, 8'h12, 8'h31, 8'h07, 8'h24, 0);
        idle(1);
        check("time_digits", obs_digits(), 32'h12B34B05);

        // Date mode entry and timed return
        key_press();
        check("key_mode_date", {31'd0, mode_date}, 32'd1);
        cnt = mode_date;
        idle(1);
        check("date_digits", obs_digits(), 32'h24B07B31);
        cnt += mode_date;
        for (int k = 0; k < 100 && mode_date; k++) begin
            idle(1);
            cnt += mode_date;
        end
        check("hold_cycles", cnt, HOLD_CYC);
        idle(1);
        check("time_after_hold", obs_digits(), 32'h12B34B05);

        // Early exit by a second key press
        key_press();
        idle(4);
        key_press();
        check("early_exit_mode", {31'd0, mode_date}, 32'd0);

        // Invalid minute units nibble
        step(1, 8'h05, 8'h5C, 8'h12, 8'h31, 8'h07, 8'h24, 0);
        idle(1);
        check("dash_nibble", obs_digits(), 32'h12B5BB05);

        // Key press in the timeout cycle
        key_press();
        idle(HOLD_CYC - 1);
        key_press();
        check("coincident_exit", {31'd0, mode_date}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            check("no_double_toggle", {31'd0, mode_date}, 32'd0);
        end

        // Reset in the middle of date mode
        key_press();
        idle(5);
        do_reset();
        idle(1);
        check("blank_after_rst", obs_digits(), {8{4'd10}});

        // Simultaneous capture and key press, then random traffic
        step(1, 8'h59, 8'h07, 8'h23, 8'h15, 8'h12, 8'h99, 1);
        idle(1);
        check("vld_and_key", obs_digits(), 32'h99B12B15);
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 3) == 0,
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 $urandom_range(0, 39) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
